dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed, big-endian 1024-byte data memory (32-bit words, combinational read path with long propagation delay).
- Shares the memory between the CPU load/store port (port 0) and a DMA/debug loader (port 1) using round-robin.
- Drives the memory's address, write data, write-enable and read-enable strobes.
- Waits a programmable number of cycles before sampling read data.
- Rejects misaligned or out-of-range word accesses without touching the memory.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; legal word addresses are 0..MEM_BYTES-4, 4-byte aligned.
- READ_WAIT, 2, cycles waited after the read strobe before sampling mem_dato; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-port request; bit0 = CPU, bit1 = DMA.
- we  in  2  per-port write (1) / read (0) qualifier, valid with req.
- addr0, addr1  in  32  per-port byte address.
- wdata0, wdata1  in  32  per-port write data, big-endian word.
- gnt  out  2  one-hot grant, high during the ISSUE cycle.
- done  out  2  one-hot completion pulse, one cycle.
- err  out  1  high with done when the access was rejected.
- rdata  out  32  read data, valid with done for reads; held until the next read completes.
- mem_dir  out  32  memory byte address.
- mem_writedato  out  32  memory write data.
- mem_writeEN  out  1  memory write enable.
- mem_MemRead  out  1  memory read enable.
- mem_dato  in  32  memory read data.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-access):
  - state = IDLE.
  - gnt, done, err, rdata, mem_dir, mem_writedato, mem_writeEN, mem_MemRead = 0.
  - last_grant = 1, so port 0 wins the first contest.
  - Wait counter cleared.
  - Any in-flight access is abandoned and no done is issued.
- IDLE:
  - On a clock edge with req != 0, pick the winner:
    - one requester: it wins;
    - both requesting: the port not equal to last_grant wins.
  - Latch the winner's addr, wdata and we.
  - Compute bad = (addr[1:0] != 0) or (addr > MEM_BYTES-4).
  - Next state ISSUE; gnt[winner] = 1.
  - req is sampled only in IDLE. A requester holds req until it sees gnt. req dropped before grant is simply ignored.
- ISSUE (exactly 1 cycle):
  - gnt[winner] high.
  - mem_dir and mem_writedato = latched values.
  - If !bad:
    - write: mem_writeEN = 1; memory captures at the edge ending ISSUE.
    - read: mem_MemRead = 1.
  - If bad: no strobe asserted; mem_dir is not updated.
  - Next state:
    - write or bad: DONE;
    - read with READ_WAIT > 0: WAIT, counter = READ_WAIT-1;
    - read with READ_WAIT = 0: DONE, and rdata = mem_dato sampled at the edge ending ISSUE.
- WAIT:
  - mem_MemRead and mem_dir held; mem_writeEN = 0.
  - Counter decrements each cycle.
  - At counter == 0: rdata = mem_dato, then DONE.
- DONE (1 cycle):
  - done[winner] = 1; err = bad.
  - mem_writeEN = 0, mem_MemRead = 0.
  - mem_dir and mem_writedato hold their last values; they are never returned to 0 except by reset.
  - last_grant = winner. Next state IDLE.
- Latency, with req first seen at edge E:
  - gnt in cycle E..E+1.
  - write/error done: one cycle after ISSUE (2 cycles after E).
  - read done: 2+READ_WAIT cycles after E.
- Back-to-back requests:
  - Minimum spacing between grants is 3 cycles (IDLE, ISSUE, DONE).
  - A port holding req across its own DONE re-arbitrates in IDLE; it wins again only if the other port is idle.
- rdata is not updated on writes or errors; err = 0 on all non-error completions.
- Invariant: mem_writeEN and mem_MemRead are never both high; neither is high outside ISSUE/WAIT.

Test Plan:
- Reset mid-read: assert rst_n = 0 during WAIT → all outputs 0 immediately (asynchronously), no done. After release, a port-1-only req is granted normally.
- Single write: port0 write addr = 0x10, wdata = 0xDEADBEEF. Then port0 read addr 0x10, READ_WAIT = 2 → done[0] 4 cycles after the read req edge, rdata = 0xDEADBEEF, err = 0. The memory model reports bytes 0x10..0x13 = DE AD BE EF.
- Contention: both req high from reset, port0 write 0x20 = 0x11111111, port1 write 0x24 = 0x22222222 → grant order port0 then port1. A continuing req on both yields alternating grants 0,1,0,1.
- Error paths: read addr 0x13 (misaligned) and read addr 0x3FD (> 0x3FC) → done with err = 1; mem_MemRead and mem_writeEN never asserted; rdata unchanged from its previous value.
- Boundary: write addr 0x3FC = 0xA5A5A5A5, then read it back → err = 0, rdata = 0xA5A5A5A5.
- READ_WAIT = 0 build: read 0x10 → done 2 cycles after the req edge with correct data. Check strobe exclusivity with an assertion throughout all tests.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer between the CPU port
// (port 0) and the DMA/debug loader (port 1) in front of the word-wide data
// memory. The read path of the memory is slow, so reads hold the address and
// read strobe for READ_WAIT extra cycles before rdata is captured. Accesses
// that are misaligned or past the last word are completed with err and never
// reach the memory.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no access in flight, requests are arbitrated here only
// S_ISSUE | winner granted, address/data/strobe presented to the memory
// S_WAIT  | read strobe held while the slow read path settles
// S_DONE  | one-cycle completion pulse, round-robin pointer updated
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int READ_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_writedato,
  output logic        mem_writeEN,
  output logic        mem_MemRead,
  input  logic [31:0] mem_dato
);

  // Counter only has to hold READ_WAIT-1; keep at least one bit so the
  // READ_WAIT = 0 build still has a legal (unused) register.
  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
  localparam logic [31:0]   ADDR_MAX = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state, w_state;
  logic           r_sel, w_sel;
  logic           r_last, w_last;
  logic           r_we, w_we;
  logic           r_bad, w_bad;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic [1:0]     r_gnt, w_gnt;
  logic [1:0]     r_done, w_done;
  logic           r_err, w_err;
  logic [31:0]    r_rdata, w_rdata;
  logic [31:0]    r_dir, w_dir;
  logic [31:0]    r_wdat, w_wdat;
  logic           r_wen, w_wen;
  logic           r_rd, w_rd;

  logic           w_pick;
  logic [31:0]    w_req_addr;
  logic [31:0]    w_req_wdata;
  logic           w_req_we;
  logic           w_req_bad;
  logic [1:0]     w_sel_onehot;

  // Round-robin pick: a lone requester wins, a tie goes to the port that
  // was not served last; the winner's request fields are muxed through.
  always_comb begin
    w_pick       = (req == 2'b11) ? ~r_last : req[1];
    w_req_addr   = w_pick ? addr1 : addr0;
    w_req_wdata  = w_pick ? wdata1 : wdata0;
    w_req_we     = w_pick ? we[1] : we[0];
    w_req_bad    = (w_req_addr[1:0] != 2'b00) || (w_req_addr > ADDR_MAX);
    w_sel_onehot = r_sel ? 2'b10 : 2'b01;
  end

  // Next-state and next-output logic; every output is a register so the
  // values computed here appear one edge later.
  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_last  = r_last;
    w_we    = r_we;
    w_bad   = r_bad;
    w_cnt   = r_cnt;
    w_gnt   = 2'b00;
    w_done  = 2'b00;
    w_err   = 1'b0;
    w_rdata = r_rdata;
    w_dir   = r_dir;
    w_wdat  = r_wdat;
    w_wen   = 1'b0;
    w_rd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_state = S_ISSUE;
          w_sel   = w_pick;
          w_we    = w_req_we;
          w_bad   = w_req_bad;
          w_gnt   = w_pick ? 2'b10 : 2'b01;
          w_wdat  = w_req_wdata;
          // A rejected access leaves the memory address untouched.
          if (!w_req_bad) begin
            w_dir = w_req_addr;
            w_wen = w_req_we;
            w_rd  = ~w_req_we;
          end
        end
      end
      S_ISSUE: begin
        if (r_we || r_bad) begin
          w_state = S_DONE;
          w_done  = w_sel_onehot;
          w_err   = r_bad;
        end else if (READ_WAIT == 0) begin
          w_state = S_DONE;
          w_done  = w_sel_onehot;
          w_rdata = mem_dato;
        end else begin
          w_state = S_WAIT;
          w_cnt   = CNT_INIT;
          w_rd    = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state = S_DONE;
          w_done  = w_sel_onehot;
          w_rdata = mem_dato;
        end else begin
          w_cnt = r_cnt - CW'(1);
          w_rd  = 1'b1;
        end
      end
      S_DONE: begin
        w_last  = r_sel;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_cnt   <= '0;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_dir   <= 32'd0;
      r_wdat  <= 32'd0;
      r_wen   <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_last  <= w_last;
      r_we    <= w_we;
      r_bad   <= w_bad;
      r_cnt   <= w_cnt;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_dir   <= w_dir;
      r_wdat  <= w_wdat;
      r_wen   <= w_wen;
      r_rd    <= w_rd;
    end
  end

  assign gnt           = r_gnt;
  assign done          = r_done;
  assign err           = r_err;
  assign rdata         = r_rdata;
  assign mem_dir       = r_dir;
  assign mem_writedato = r_wdat;
  assign mem_writeEN   = r_wen;
  assign mem_MemRead   = r_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level timing model predicts every
// output per cycle for the READ_WAIT = 2 instance; a second READ_WAIT = 0
// instance is checked with literal expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int RW        = 2;
  localparam int NC        = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req, we, gnt, done;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_dir, mem_writedato, mem_dato;
  logic        err, mem_writeEN, mem_MemRead;

  logic [1:0]  z_req, z_we, z_gnt, z_done;
  logic [31:0] z_addr0, z_addr1, z_wdata0, z_wdata1, z_rdata, z_mem_dir, z_mem_writedato, z_mem_dato;
  logic        z_err, z_mem_writeEN, z_mem_MemRead;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .READ_WAIT(RW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_dir(mem_dir), .mem_writedato(mem_writedato), .mem_writeEN(mem_writeEN),
    .mem_MemRead(mem_MemRead), .mem_dato(mem_dato));

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .READ_WAIT(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .req(z_req), .we(z_we), .addr0(z_addr0), .addr1(z_addr1),
    .wdata0(z_wdata0), .wdata1(z_wdata1), .gnt(z_gnt), .done(z_done), .err(z_err), .rdata(z_rdata),
    .mem_dir(z_mem_dir), .mem_writedato(z_mem_writedato), .mem_writeEN(z_mem_writeEN),
    .mem_MemRead(z_mem_MemRead), .mem_dato(z_mem_dato));

  // Big-endian byte memories with combinational read.
  logic [7:0] tmem [0:MEM_BYTES-1];
  logic [7:0] zmem [0:MEM_BYTES-1];
  always_comb mem_dato = {tmem[{mem_dir[9:2], 2'b00}], tmem[{mem_dir[9:2], 2'b01}],
                          tmem[{mem_dir[9:2], 2'b10}], tmem[{mem_dir[9:2], 2'b11}]};
  always_comb z_mem_dato = {zmem[{z_mem_dir[9:2], 2'b00}], zmem[{z_mem_dir[9:2], 2'b01}],
                            zmem[{z_mem_dir[9:2], 2'b10}], zmem[{z_mem_dir[9:2], 2'b11}]};
  always @(posedge clk) begin
    if (mem_writeEN) begin
      tmem[{mem_dir[9:2], 2'b00}] <= mem_writedato[31:24];
      tmem[{mem_dir[9:2], 2'b01}] <= mem_writedato[23:16];
      tmem[{mem_dir[9:2], 2'b10}] <= mem_writedato[15:8];
      tmem[{mem_dir[9:2], 2'b11}] <= mem_writedato[7:0];
    end
    if (z_mem_writeEN) begin
      zmem[{z_mem_dir[9:2], 2'b00}] <= z_mem_writedato[31:24];
      zmem[{z_mem_dir[9:2], 2'b01}] <= z_mem_writedato[23:16];
      zmem[{z_mem_dir[9:2], 2'b10}] <= z_mem_writedato[15:8];
      zmem[{z_mem_dir[9:2], 2'b11}] <= z_mem_writedato[7:0];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no completion within cycle budget (t=%0t)", nm, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // Per-cycle expectation tables indexed by the number of rising edges seen.
  int          cyc = 0;
  logic [1:0]  e_gnt [NC];
  logic [1:0]  e_done [NC];
  logic        e_err [NC];
  logic        e_wen [NC];
  logic        e_rd [NC];
  logic        e_rdv [NC];
  logic [31:0] e_dir [NC];
  logic [31:0] e_wd [NC];
  logic [31:0] e_rdval [NC];
  logic [31:0] m_ref [0:255];
  int          m_free = 0;
  int          m_last = 1;
  logic [31:0] m_rdata = 32'd0;
  int          m_w, m_d;
  logic [31:0] m_a, m_wd;
  logic        m_isw, m_bad;

  task automatic clear_from(input int from);
    for (int k = from; k < NC; k++) begin
      e_gnt[k] = 2'b00; e_done[k] = 2'b00; e_err[k] = 1'b0; e_wen[k] = 1'b0;
      e_rd[k] = 1'b0; e_rdv[k] = 1'b0; e_dir[k] = 32'd0; e_wd[k] = 32'd0; e_rdval[k] = 32'd0;
    end
  endtask

  // A request seen at edge t occupies the arbiter for d cycles (2 for writes
  // and rejects, 2+RW for reads) and the next request is sampled at t+d+1.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && cyc >= m_free && req != 2'b00 && cyc + RW + 8 < NC) begin
      if (req == 2'b11) m_w = 1 - m_last;
      else              m_w = req[1] ? 1 : 0;
      m_a   = (m_w == 1) ? addr1 : addr0;
      m_wd  = (m_w == 1) ? wdata1 : wdata0;
      m_isw = we[m_w];
      m_bad = (m_a % 4 != 0) || (m_a > MEM_BYTES - 4);
      m_d   = (m_isw || m_bad) ? 2 : 2 + RW;
      e_gnt[cyc] = (m_w == 1) ? 2'b10 : 2'b01;
      if (!m_bad) begin
        if (m_isw) begin
          e_wen[cyc] = 1'b1;
          e_dir[cyc] = m_a;
          e_wd[cyc]  = m_wd;
          m_ref[m_a / 4] = m_wd;
        end else begin
          for (int k = 0; k <= RW; k++) begin
            e_rd[cyc + k]  = 1'b1;
            e_dir[cyc + k] = m_a;
          end
        end
      end
      e_done[cyc + m_d - 1] = (m_w == 1) ? 2'b10 : 2'b01;
      e_err[cyc + m_d - 1]  = m_bad;
      if (!m_isw && !m_bad) begin
        e_rdv[cyc + m_d - 1]   = 1'b1;
        e_rdval[cyc + m_d - 1] = m_ref[m_a / 4];
      end
      m_last = m_w;
      m_free = cyc + m_d + 1;
    end
  end

  always @(negedge rst_n) begin
    clear_from(cyc);
    m_free  = 0;
    m_last  = 1;
    m_rdata = 32'd0;
  end

  // ---------------- per-cycle compare ----------------
  int n_strobe = 0;
  int glog[$];

  always @(negedge clk) begin
    if (e_rdv[cyc]) m_rdata = e_rdval[cyc];
    chk("gnt",   32'(gnt),         32'(e_gnt[cyc]));
    chk("done",  32'(done),        32'(e_done[cyc]));
    chk("err",   32'(err),         32'(e_err[cyc]));
    chk("wen",   32'(mem_writeEN), 32'(e_wen[cyc]));
    chk("mrd",   32'(mem_MemRead), 32'(e_rd[cyc]));
    chk("rdata", rdata,            m_rdata);
    if (e_wen[cyc] || e_rd[cyc]) chk("mem_dir", mem_dir, e_dir[cyc]);
    if (e_wen[cyc]) chk("mem_wdat", mem_writedato, e_wd[cyc]);
    chk("excl",   32'(mem_writeEN & mem_MemRead), 32'd0);
    chk("z_excl", 32'(z_mem_writeEN & z_mem_MemRead), 32'd0);
    assert (!(mem_writeEN && mem_MemRead));
    assert (!(z_mem_writeEN && z_mem_MemRead));
    if (mem_writeEN || mem_MemRead) n_strobe++;
    if (gnt != 2'b00) glog.push_back(gnt[1] ? 1 : 0);
  end

  // ---------------- drivers ----------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;
  txn_t q0[$];
  txn_t q1[$];

  task automatic update_ports();
    req[0] = (q0.size() != 0);
    if (q0.size() != 0) begin we[0] = q0[0].w; addr0 = q0[0].a; wdata0 = q0[0].d; end
    req[1] = (q1.size() != 0);
    if (q1.size() != 0) begin we[1] = q1[0].w; addr1 = q1[0].a; wdata1 = q1[0].d; end
  endtask

  // Each port keeps req high while it has work and advances on its grant.
  task automatic run_queues(input int budget);
    int n;
    n = 0;
    update_ports();
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk); #2;
      n++;
      if (gnt[0] && q0.size() != 0) void'(q0.pop_front());
      if (gnt[1] && q1.size() != 0) void'(q1.pop_front());
      update_ports();
    end
    if (n >= budget) timeout("run_queues");
    req = 2'b00;
    repeat (3) @(posedge clk);
    #2;
  endtask

  // One access on the RW=2 instance; lat counts edges from the first
  // sampling edge to the edge that raises done.
  task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er, output logic [1:0] g);
    bit got;
    got = 0; lat = 0; rd = 32'd0; er = 1'b0; g = 2'b00;
    req[p] = 1'b1; we[p] = w;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #2;
      if (gnt[p]) begin req[p] = 1'b0; g = gnt; end
      if (done != 2'b00) begin lat = n; rd = rdata; er = err; got = 1; end
    end
    req[p] = 1'b0;
    if (!got) timeout("single");
    @(posedge clk); #2;
  endtask

  task automatic z_single(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
    bit got;
    got = 0; lat = 0; rd = 32'd0; er = 1'b0;
    z_req[0] = 1'b1; z_we[0] = w; z_addr0 = a; z_wdata0 = d;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #2;
      if (z_gnt[0]) z_req[0] = 1'b0;
      if (z_done != 2'b00) begin lat = n; rd = z_rdata; er = z_err; got = 1; end
    end
    z_req[0] = 1'b0;
    if (!got) timeout("z_single");
    @(posedge clk); #2;
  endtask

  // ---------------- directed sequence ----------------
  int          lat;
  logic [31:0] rd;
  logic        er;
  logic [1:0]  g;
  int          s0;
  int          exp_order [4];

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin tmem[i] = 8'h00; zmem[i] = 8'h00; end
    for (int i = 0; i < 256; i++) m_ref[i] = 32'd0;
    zmem[16] = 8'hCA; zmem[17] = 8'hFE; zmem[18] = 8'hF0; zmem[19] = 8'h0D;
    clear_from(0);
    req = 2'b00; we = 2'b00; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    z_req = 2'b00; z_we = 2'b00; z_addr0 = 0; z_addr1 = 0; z_wdata0 = 0; z_wdata1 = 0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_rdata", rdata,    32'd0);
    chk("rst_dir",   mem_dir,  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // READ_WAIT = 0 instance
    z_single(1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("z_rd_lat", 32'(lat), 32'd2);
    chk("z_rd_data", rd, 32'hCAFEF00D);
    chk("z_rd_err", 32'(er), 32'd0);
    z_single(1'b1, 32'h3FC, 32'h5A5A1234, lat, rd, er);
    chk("z_wr_lat", 32'(lat), 32'd2);
    z_single(1'b0, 32'h3FC, 32'h0, lat, rd, er);
    chk("z_bnd_data", rd, 32'h5A5A1234);

    // single write then read-back
    single(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, g);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_gnt", 32'(g), 32'd1);
    chk("mem_b10", 32'(tmem[16]), 32'hDE);
    chk("mem_b11", 32'(tmem[17]), 32'hAD);
    chk("mem_b12", 32'(tmem[18]), 32'hBE);
    chk("mem_b13", 32'(tmem[19]), 32'hEF);
    single(0, 1'b0, 32'h10, 32'h0, lat, rd, er, g);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    // rejected accesses
    s0 = n_strobe;
    single(0, 1'b0, 32'h13, 32'h0, lat, rd, er, g);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_lat", 32'(lat), 32'd2);
    chk("mis_rdata", rd, 32'hDEADBEEF);
    single(1, 1'b0, 32'h3FD, 32'h0, lat, rd, er, g);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'hDEADBEEF);
    chk("err_strobes", 32'(n_strobe - s0), 32'd0);

    // last legal word
    single(1, 1'b1, 32'h3FC, 32'hA5A5A5A5, lat, rd, er, g);
    chk("bnd_wr_err", 32'(er), 32'd0);
    single(0, 1'b0, 32'h3FC, 32'h0, lat, rd, er, g);
    chk("bnd_rd_err", 32'(er), 32'd0);
    chk("bnd_rd_data", rd, 32'hA5A5A5A5);

    // reset in the middle of a read
    req[0] = 1'b1; we[0] = 1'b0; addr0 = 32'h10;
    @(posedge clk); #2;
    chk("rmr_gnt", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    @(posedge clk); #2;
    chk("rmr_mrd", 32'(mem_MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmr_gnt0",  32'(gnt), 32'd0);
    chk("rmr_done0", 32'(done), 32'd0);
    chk("rmr_err0",  32'(err), 32'd0);
    chk("rmr_rdata", rdata, 32'd0);
    chk("rmr_dir",   mem_dir, 32'd0);
    chk("rmr_wdat",  mem_writedato, 32'd0);
    chk("rmr_wen",   32'(mem_writeEN), 32'd0);
    chk("rmr_mrd0",  32'(mem_MemRead), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    single(1, 1'b0, 32'h10, 32'h0, lat, rd, er, g);
    chk("p1_gnt", 32'(g), 32'd2);
    chk("p1_lat", 32'(lat), 32'd4);
    chk("p1_data", rd, 32'hDEADBEEF);

    // contention from reset
    rst_n = 1'b0;
    q0.push_back('{w: 1'b1, a: 32'h20, d: 32'h11111111});
    q0.push_back('{w: 1'b1, a: 32'h28, d: 32'h33333333});
    q1.push_back('{w: 1'b1, a: 32'h24, d: 32'h22222222});
    q1.push_back('{w: 1'b1, a: 32'h2C, d: 32'h44444444});
    update_ports();
    @(posedge clk); #2;
    glog.delete();
    rst_n = 1'b1;
    run_queues(60);
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    chk("order_len", 32'(glog.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("order_%0d", k), 32'((glog.size() > k) ? glog[k] : 99), 32'(exp_order[k]));
    single(1, 1'b0, 32'h24, 32'h0, lat, rd, er, g);
    chk("c_rd24", rd, 32'h22222222);
    single(0, 1'b0, 32'h20, 32'h0, lat, rd, er, g);
    chk("c_rd20", rd, 32'h11111111);
    single(0, 1'b0, 32'h2C, 32'h0, lat, rd, er, g);
    chk("c_rd2c", rd, 32'h44444444);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
